// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch-side front end for the pipelined RISC-V core. It issues one word fetch
// at a time to instruction memory over a ready/valid handshake, buffers the
// returned {pc, instr} pairs in a small FIFO and presents the head entry to the
// IF/ID register. A taken branch/jump redirect flushes the FIFO, discards any
// in-flight response and restarts fetching at the new address.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   mem_req       fetch request valid
//   mem_addr      fetch address
//   mem_ready     memory accepts the request this cycle
//   mem_rvalid    read data valid (responses return in order)
//   mem_rdata     instruction word
//   stallF        consumer is not taking the head entry this cycle
//   redirect      taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc   new fetch address
//   instr_valid   head entry valid
//   instrF        head instruction (NOP when empty)
//   PCF           head pc (0 when empty)
//   PCPlus4F      PCF + 4, wrapping modulo 2^32
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    // IDLE : may issue a request
    // WAIT : one request outstanding, its data will be kept
    // DRAIN: one request outstanding, its data is stale (redirect happened)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        mem_req    = 1'b0;
        push       = 1'b0;

        unique case (state)
            IDLE: begin
                // rst gating keeps the request low for the whole reset pulse,
                // not just after the first edge.
                mem_req = ~rst & (count < DEPTH_CNT) & ~redirect;
                if (mem_req && mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // Data arriving with the redirect is simply dropped.
                    state_next = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = mem_req & mem_ready;
    // Pops are cancelled by a redirect: the whole queue is being thrown away.
    assign pop    = instr_valid & ~stallF & ~redirect;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;

            if (redirect) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // Only one request is ever outstanding and it is issued only
                // with space available, so a push never meets a full FIFO.
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never observed and the array can map onto plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= mem_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Head presentation
    // -------------------------------------------------------------------------
    assign mem_addr    = fetch_pc;
    assign instr_valid = (count != '0);
    assign instrF      = instr_valid ? instr_mem[rd_ptr] : NOP;
    assign PCF         = instr_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign PCPlus4F    = PCF + 32'd4;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Randomised bench for instr_prefetch_queue. A driver plays the instruction
// memory and the pipeline (stalls, redirects) and keeps a transaction-level
// model: the list of fetched-but-unconsumed {pc, instr} pairs, the next fetch
// address and whether a response is still owed (and whether it is stale).
// Expected entries go into a scoreboard queue; a monitor compares the head the
// DUT presents against that queue and retires entries as they are consumed.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stallF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stallF      (stallF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instrF      (instrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t sb_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [31:0] m_fetch_pc;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_out_addr;
    int          m_lat;
    bit          pend_push;
    bit          pend_flush;
    entry_t      pend_entry;

    // Stimulus knobs (percentages / bounds)
    int k_ready, k_stall, k_redir, k_lat_max, k_spur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // One clock of memory + pipeline behaviour and model bookkeeping.
    task automatic drive_cycle();
        bit rv_gen;
        bit exp_req;
        @(negedge clk);
        rv_gen = 1'b0;
        if (m_out && m_lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = m_out_addr ^ KEY;
            rv_gen     = 1'b1;
        end else begin
            if (m_out) m_lat--;
            // Unsolicited rvalid while nothing is owed must be ignored.
            mem_rvalid = !m_out && pct(k_spur);
            mem_rdata  = $urandom();
        end
        mem_ready = pct(k_ready);
        stallF    = pct(k_stall);
        redirect  = pct(k_redir);
        case ($urandom_range(0, 3))
            0:       redirect_pc = 32'hFFFF_FFFC;
            1:       redirect_pc = 32'h0000_0100;
            2:       redirect_pc = 32'hFFFF_FFF8;
            default: redirect_pc = $urandom();
        endcase
        #1;
        exp_req = !m_out && (sb_q.size() < DEPTH) && !redirect;
        check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        if (mem_req && exp_req) check("mem_addr", mem_addr, m_fetch_pc);

        if (redirect) begin
            m_fetch_pc = redirect_pc;
            pend_flush = 1'b1;
            if (m_out) begin
                if (rv_gen) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (rv_gen) begin
                if (!m_stale) begin
                    pend_push  = 1'b1;
                    pend_entry = '{pc: m_out_addr, instr: mem_rdata};
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req && mem_ready) begin
                m_out      = 1'b1;
                m_stale    = 1'b0;
                m_out_addr = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_lat      = int'($urandom_range(0, k_lat_max));
            end
        end

        @(posedge clk);
        #1;
        if (pend_flush) sb_q.delete();
        if (pend_push) begin
            check("push_space", {31'b0, sb_q.size() < DEPTH}, 32'd1);
            sb_q.push_back(pend_entry);
        end
        pend_flush = 1'b0;
        pend_push  = 1'b0;
    endtask

    // Monitor: compares the presented head with the scoreboard and retires it
    // when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst || !mon_en) continue;
            check("instr_valid", {31'b0, instr_valid}, {31'b0, sb_q.size() != 0});
            if (sb_q.size() == 0) begin
                check("empty_instrF", instrF, NOP);
                check("empty_PCF", PCF, 32'h0);
                check("empty_PCPlus4F", PCPlus4F, 32'd4);
            end else begin
                check("head_PCF", PCF, sb_q[0].pc);
                check("head_instrF", instrF, sb_q[0].instr);
                check("head_PCPlus4F", PCPlus4F, sb_q[0].pc + 32'd4);
                if (!stallF && !redirect) void'(sb_q.pop_front());
            end
        end
    end

    task automatic run(input int n, input int rdy, input int stl, input int rdr,
                       input int lat, input int spur);
        k_ready   = rdy;
        k_stall   = stl;
        k_redir   = rdr;
        k_lat_max = lat;
        k_spur    = spur;
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    initial begin
        bit found;
        rst         = 1'b1;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        stallF      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        m_fetch_pc  = RESET_PC;
        m_out       = 1'b0;
        m_stale     = 1'b0;
        m_out_addr  = '0;
        m_lat       = 0;
        pend_push   = 1'b0;
        pend_flush  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instrF", instrF, NOP);
        check("rst_PCF", PCF, 32'h0);
        check("rst_PCPlus4F", PCPlus4F, 32'd4);
        check("rst_mem_addr", mem_addr, RESET_PC);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Streaming with a 1-cycle memory, no stalls
        run(30, 100, 0, 0, 0, 0);
        // Consumer stalled until the FIFO fills, then released
        run(30, 100, 100, 0, 0, 0);
        run(20, 100, 0, 0, 0, 0);
        // Backpressure from memory with a steady request
        run(30, 25, 0, 0, 0, 0);
        // Randomised mixes of backpressure, stalls, redirects and latency
        for (int b = 0; b < 12; b++) begin
            run(150, int'($urandom_range(30, 100)), int'($urandom_range(0, 70)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 30)));
        end

        // Park the DUT in WAIT, then hit it with an asynchronous reset mid-cycle
        k_ready = 100; k_stall = 0; k_redir = 0; k_lat_max = 0; k_spur = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            k_lat_max = 6;
            drive_cycle();
            found = m_out && !m_stale && (m_lat > 0);
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_state: no outstanding request reached within budget");
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("async_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async_rst_instrF", instrF, NOP);
        check("async_rst_PCF", PCF, 32'h0);
        check("async_rst_PCPlus4F", PCPlus4F, 32'd4);
        check("async_rst_mem_addr", mem_addr, RESET_PC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
